// File: rtl/riscuinho_pkg.sv
// Shared definitions for the riscuinho integer core: data-size encodings,
// LSU state enum and the load-extension helper.
package riscuinho_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    // Select the byte/half/word from an already lane-shifted value and extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] shifted,
                                                input logic [1:0]  size,
                                                input logic        is_unsigned);
        logic [31:0] result;
        case (size)
            SIZE_B:  result = is_unsigned ? {24'd0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_H:  result = is_unsigned ? {16'd0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            SIZE_W:  result = shifted;
            default: result = 32'd0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the load/store unit: byte enables, replicated
// store data, misalignment detection and extended load data.
module lsu_align
    import riscuinho_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        unsigned_value,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned,
    output logic [31:0] load_ext
);

    logic [31:0] shifted_s;

    // Lane selection for stores and alignment check.
    always_comb begin
        be         = 4'b0000;
        wdata      = 32'd0;
        misaligned = 1'b0;
        case (size)
            SIZE_B: begin
                be    = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            SIZE_H: begin
                be         = 4'b0011 << offset;
                wdata      = {2{store_data[15:0]}};
                misaligned = offset[0];
            end
            SIZE_W: begin
                be         = 4'b1111;
                wdata      = store_data;
                misaligned = (offset != 2'b00);
            end
            default: begin
                be         = 4'b0000;
                wdata      = 32'd0;
                misaligned = 1'b0;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend.
    always_comb begin
        shifted_s = rdata >> {offset, 3'b000};
        load_ext  = load_extend(shifted_s, size, unsigned_value);
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: runs one request/acknowledge bus transaction per
// load or store and returns extended load data with a done/error pulse.
module load_store_unit
    import riscuinho_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        data_r,
    input  logic        data_w,
    input  logic [1:0]  data_size,
    input  logic        unsigned_value,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] load_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);

    lsu_state_e  state_r;
    logic [1:0]  size_r;
    logic [1:0]  off_r;
    logic        uns_r;
    logic        load_r;
    logic [31:0] cnt_r;
    logic        busy_r;
    logic        done_r;
    logic        error_r;
    logic [31:0] load_data_r;
    logic        bus_req_r;
    logic        bus_we_r;
    logic [31:0] bus_addr_r;
    logic [3:0]  bus_be_r;
    logic [31:0] bus_wdata_r;

    logic [1:0]  al_size_s;
    logic [1:0]  al_off_s;
    logic        al_uns_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic        misaligned_s;
    logic [31:0] ld_ext_s;
    logic        reject_s;
    logic        noop_s;
    logic        timeout_hit_s;

    // In IDLE the aligner sees the live request; afterwards the latched one.
    always_comb begin
        if (state_r == ST_IDLE) begin
            al_size_s = data_size;
            al_off_s  = addr[1:0];
            al_uns_s  = unsigned_value;
        end else begin
            al_size_s = size_r;
            al_off_s  = off_r;
            al_uns_s  = uns_r;
        end
    end

    lsu_align u_align (
        .size           (al_size_s),
        .offset         (al_off_s),
        .unsigned_value (al_uns_s),
        .store_data     (store_data),
        .rdata          (bus_rdata),
        .be             (be_s),
        .wdata          (wdata_s),
        .misaligned     (misaligned_s),
        .load_ext       (ld_ext_s)
    );

    // Request classification and timeout detection.
    always_comb begin
        reject_s      = misaligned_s | (data_size == SIZE_X) | (data_r & data_w);
        noop_s        = ~data_r & ~data_w;
        timeout_hit_s = (TIMEOUT_C != 32'd0) && ((cnt_r + 32'd1) == TIMEOUT_C);
    end

    // Access FSM with registered bus and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            size_r      <= 2'b00;
            off_r       <= 2'b00;
            uns_r       <= 1'b0;
            load_r      <= 1'b0;
            cnt_r       <= 32'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            load_data_r <= 32'd0;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'd0;
            bus_be_r    <= 4'b0000;
            bus_wdata_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r  <= 1'b0;
                    error_r <= 1'b0;
                    if (start) begin
                        size_r <= data_size;
                        off_r  <= addr[1:0];
                        uns_r  <= unsigned_value;
                        load_r <= data_r;
                        if (reject_s) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            error_r <= 1'b1;
                        end else if (noop_s) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r     <= ST_REQ;
                            cnt_r       <= 32'd0;
                            busy_r      <= 1'b1;
                            bus_req_r   <= 1'b1;
                            bus_we_r    <= data_w;
                            bus_addr_r  <= {addr[31:2], 2'b00};
                            bus_be_r    <= be_s;
                            bus_wdata_r <= data_w ? wdata_s : 32'd0;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus_ack || timeout_hit_s) begin
                        state_r     <= ST_DONE;
                        done_r      <= 1'b1;
                        error_r     <= ~bus_ack;
                        busy_r      <= 1'b0;
                        bus_req_r   <= 1'b0;
                        bus_we_r    <= 1'b0;
                        bus_addr_r  <= 32'd0;
                        bus_be_r    <= 4'b0000;
                        bus_wdata_r <= 32'd0;
                        cnt_r       <= 32'd0;
                        if (bus_ack && load_r) begin
                            load_data_r <= ld_ext_s;
                        end
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    error_r <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    done_r    <= 1'b0;
                    error_r   <= 1'b0;
                    busy_r    <= 1'b0;
                    bus_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign error     = error_r;
    assign load_data = load_data_r;
    assign bus_req   = bus_req_r;
    assign bus_we    = bus_we_r;
    assign bus_addr  = bus_addr_r;
    assign bus_be    = bus_be_r;
    assign bus_wdata = bus_wdata_r;

endmodule
